serial_alu_responder: RTL and testbench
=======================================

Name: serial_alu_responder

Overview:
- ALU-side endpoint of the processor↔ALU serial link.
- Deserializes one Isa::AluPacket, bit-serial with op_code first, then executes the operation.
- Serializes the REGISTER_SIZE-bit result back to the processor.
- One packet in flight at a time; processor-side transmitter/receiver is the peer.

Parameters:
- DATA_WIDTH, default Isa::REGISTER_SIZE (32): operand/result width used by the datapath.
- PACKET_WIDTH, default $bits(Isa::AluPacket) (68): bits received per request.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rx_valid  in  1  rx_bit carries a valid packet bit this cycle
- rx_bit  in  1  serial packet bit
- rx_ready  out  1  responder accepts a bit this cycle
- tx_valid  out  1  tx_bit carries a valid result bit
- tx_bit  out  1  serial result bit
- tx_last  out  1  high with the final (MSB) result bit
- tx_ready  in  1  processor accepts tx_bit this cycle
- busy  out  1  high whenever state != RECEIVE or bit counter != 0

Behaviour:
- Reset (async assert, sync release): state=RECEIVE, counters=0, shift/result registers=0; rx_ready=1, tx_valid=0, tx_bit=0, tx_last=0, busy=0.
- Transfer rule, both directions: a bit transfers on a rising edge when valid&&ready. Gaps (valid low) are allowed anywhere and do not advance counters.
- Bit order: packet sent LSB-first of the packed struct.
  - op_code bits 0..1 first, then op_1 bits 0..32, then op_2 bits 0..32.
  - Result sent LSB-first, bit 0..DATA_WIDTH-1.
- Operand fields are DATA_WIDTH+1 bits. Bit DATA_WIDTH of each operand is received and ignored; the datapath uses the low DATA_WIDTH bits.
- FSM, three states:
  - RECEIVE: rx_ready=1. Each accepted bit shifts into a PACKET_WIDTH register at the MSB end (shift right), so the struct is aligned after the final bit. rx_cnt increments. When the accepted bit has rx_cnt==PACKET_WIDTH-1: rx_cnt←0, go to EXECUTE.
  - EXECUTE (exactly 1 cycle): rx_ready=0. Result register ← ADD/SUB/AND/OR of op_1, op_2, modulo 2^DATA_WIDTH (SUB = op_1 - op_2, wraps). tx_cnt←0. Go to TRANSMIT.
  - TRANSMIT: rx_ready=0, tx_valid=1, tx_bit=result[tx_cnt], tx_last=(tx_cnt==DATA_WIDTH-1).
    - On tx accept with !tx_last: tx_cnt++.
    - On tx accept with tx_last: go to RECEIVE.
    - tx_bit/tx_last hold stable while tx_ready=0.
- Latency: last rx bit accepted at edge N → tx_valid high from cycle after edge N+1; with tx_ready held high, result fully sent after DATA_WIDTH further edges.
- rx_ready is combinational from state only (1 iff RECEIVE). rx_valid is ignored outside RECEIVE; no bits are dropped, since the peer must wait for ready.
- Back-to-back: the first bit of the next packet can be accepted on the edge after tx_last transfers.
- All op_code encodings are defined (2-bit enum); no illegal-op handling needed.
- Reset mid-receive or mid-transmit: immediate return to reset state; partial packet discarded, no tx_valid pulse.

Decomposition:
- Isa package additions:
  - ALU_PACKET_WIDTH = $bits(AluPacket)
  - ALU_RESULT_WIDTH = REGISTER_SIZE
  - typedef enum AluLinkState {RECEIVE, EXECUTE, TRANSMIT}
- Sub-module alu_core: purely combinational (op_code, op_1, op_2 → result), reused by any future parallel ALU. FSM, shift and counters stay in serial_alu_responder.

Test Plan:
- ADD, op_1=5, op_2=3, continuous rx_valid/tx_ready → result 0x00000008 LSB-first; tx_last on 32nd bit; tx_valid first appears 2 cycles after last rx edge.
- SUB, op_1=3, op_2=5 → 0xFFFFFFFE. ADD 0xFFFFFFFF+1 → 0x00000000 (wrap).
- AND 0xF0F0A5A5 & 0x0FF0FFFF → 0x00F0A5A5. OR same operands → 0xFFF0FFFF. Operand bit 32 set to 1 has no effect on either result.
- Random rx_valid gaps and tx_ready stalls (50% duty): rx_ready low throughout EXECUTE/TRANSMIT; tx_bit/tx_last stable while stalled; result identical to no-stall run.
- rst_n asserted after 40 packet bits, then a clean OR packet (op_1=0x1, op_2=0x2): outputs reset asynchronously, no tx_valid before the new packet completes, result 0x00000003.
- Two back-to-back packets: second packet's first bit accepted on the edge after first tx_last transfer; both results correct.

Source files
------------

// File: rtl/serial_alu_responder_pkg.sv
// Shared ISA definitions for the processor<->ALU serial link: packet layout,
// ALU op encodings and the responder's link states.
package serial_alu_responder_pkg;

    localparam int REGISTER_SIZE = 32;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_e;

    // First member is the MSB end, so op_code sits in the low bits and goes out first.
    typedef struct packed {
        logic [REGISTER_SIZE:0] op_2;
        logic [REGISTER_SIZE:0] op_1;
        alu_op_e                op_code;
    } alu_packet_t;

    localparam int ALU_PACKET_WIDTH = $bits(alu_packet_t);
    localparam int ALU_RESULT_WIDTH = REGISTER_SIZE;

    typedef enum logic [1:0] {
        RECEIVE  = 2'd0,
        EXECUTE  = 2'd1,
        TRANSMIT = 2'd2
    } alu_link_state_e;

endpackage

// File: rtl/serial_alu_responder_core.sv
// Purely combinational ALU: ADD/SUB/AND/OR on two DATA_WIDTH operands,
// results wrap modulo 2^DATA_WIDTH.
module alu_core
    import serial_alu_responder_pkg::*;
#(
    parameter int DATA_WIDTH = REGISTER_SIZE
) (
    input  logic [1:0]            op_code,
    input  logic [DATA_WIDTH-1:0] op_1,
    input  logic [DATA_WIDTH-1:0] op_2,
    output logic [DATA_WIDTH-1:0] result
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        result = '0;
        case (alu_op_e'(op_code))
            ALU_ADD: result = op_1 + op_2;
            ALU_SUB: result = op_1 - op_2;
            ALU_AND: result = op_1 & op_2;
            ALU_OR:  result = op_1 | op_2;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/serial_alu_responder.sv
// ALU-side endpoint of the serial link: deserializes one packet, executes it
// for one cycle, then serializes the result LSB-first back to the processor.
module serial_alu_responder
    import serial_alu_responder_pkg::*;
#(
    parameter int DATA_WIDTH   = REGISTER_SIZE,
    parameter int PACKET_WIDTH = ALU_PACKET_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_valid,
    input  logic rx_bit,
    output logic rx_ready,
    output logic tx_valid,
    output logic tx_bit,
    output logic tx_last,
    input  logic tx_ready,
    output logic busy
);

    localparam int RX_CW     = $clog2(PACKET_WIDTH);
    localparam int TX_CW     = $clog2(DATA_WIDTH);
    localparam int OP_1_LSB  = 2;
    localparam int OP_2_LSB  = OP_1_LSB + DATA_WIDTH + 1;
    localparam logic [RX_CW-1:0] RX_LAST = RX_CW'(PACKET_WIDTH - 1);
    localparam logic [TX_CW-1:0] TX_LAST = TX_CW'(DATA_WIDTH - 1);

    alu_link_state_e         state, state_next;
    logic [PACKET_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0]   result_q;
    logic [DATA_WIDTH-1:0]   alu_result;
    logic [RX_CW-1:0]        rx_cnt;
    logic [TX_CW-1:0]        tx_cnt;
    logic                    rx_at_last;
    logic                    tx_at_last;
    logic                    ext_bits_unused;

    assign rx_at_last = (rx_cnt == RX_LAST);
    assign tx_at_last = (tx_cnt == TX_LAST);
    assign busy       = (state != RECEIVE) || (rx_cnt != '0);

    // The top bit of each operand field travels on the link but never feeds the datapath.
    assign ext_bits_unused = shift_q[OP_1_LSB + DATA_WIDTH] ^ shift_q[OP_2_LSB + DATA_WIDTH];

    alu_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu_core (
        .op_code (shift_q[1:0]),
        .op_1    (shift_q[OP_1_LSB +: DATA_WIDTH]),
        .op_2    (shift_q[OP_2_LSB +: DATA_WIDTH]),
        .result  (alu_result)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RECEIVE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rx_ready   = 1'b0;
        tx_valid   = 1'b0;
        tx_bit     = 1'b0;
        tx_last    = 1'b0;
        case (state)
            RECEIVE: begin
                rx_ready = 1'b1;
                if (rx_valid && rx_at_last) begin
                    state_next = EXECUTE;
                end
            end
            EXECUTE: begin
                state_next = TRANSMIT;
            end
            TRANSMIT: begin
                tx_valid = 1'b1;
                tx_bit   = result_q[tx_cnt];
                tx_last  = tx_at_last;
                if (tx_ready && tx_at_last) begin
                    state_next = RECEIVE;
                end
            end
            default: state_next = RECEIVE;
        endcase
    end

    // NOTE: the shift and result registers are plain flops, not RAM, so they reset with the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= '0;
            result_q <= '0;
            rx_cnt   <= '0;
            tx_cnt   <= '0;
        end else begin
            case (state)
                RECEIVE: begin
                    if (rx_valid) begin
                        shift_q <= {rx_bit, shift_q[PACKET_WIDTH-1:1]};
                        rx_cnt  <= rx_at_last ? '0 : rx_cnt + 1'b1;
                    end
                end
                EXECUTE: begin
                    result_q <= alu_result;
                    tx_cnt   <= '0;
                end
                TRANSMIT: begin
                    if (tx_ready && !tx_at_last) begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_responder.sv
// Randomized scoreboard bench for serial_alu_responder: stimulus pushes expected
// results, a monitor reassembles the serial result and compares.
module tb_serial_alu_responder;
    import serial_alu_responder_pkg::*;

    localparam int DW = ALU_RESULT_WIDTH;
    localparam int PW = ALU_PACKET_WIDTH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_valid = 1'b0;
    logic rx_bit = 1'b0;
    logic tx_ready = 1'b1;
    logic rx_ready, tx_valid, tx_bit, tx_last, busy;
    bit   stall_en = 1'b0;

    int unsigned cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int first_accept_cyc = 0;
    int last_tx_cyc = 0;
    logic [DW-1:0] sb[$];

    serial_alu_responder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_valid (rx_valid),
        .rx_bit   (rx_bit),
        .rx_ready (rx_ready),
        .tx_valid (tx_valid),
        .tx_bit   (tx_bit),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] model(alu_op_e op, logic [DW-1:0] a, logic [DW-1:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            default: return a | b;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            tx_ready = stall_en ? 1'($urandom_range(1)) : 1'b1;
        end
    end

    // Monitor: collects accepted result bits and checks handshake invariants.
    initial begin
        logic [DW-1:0] acc;
        int idx;
        logic prev_stall, prev_bit, prev_last;
        acc = '0;
        idx = 0;
        prev_stall = 1'b0;
        prev_bit = 1'b0;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                idx = 0;
                acc = '0;
                prev_stall = 1'b0;
                continue;
            end
            if (tx_valid) begin
                check("rx_ready low while transmitting", rx_ready, 1'b0);
                check("busy while transmitting", busy, 1'b1);
                if (sb.size() == 0) check("unexpected tx_valid", tx_valid, 1'b0);
            end
            if (prev_stall) begin
                check("tx_valid held while stalled", tx_valid, 1'b1);
                check("tx_bit stable while stalled", tx_bit, prev_bit);
                check("tx_last stable while stalled", tx_last, prev_last);
            end
            if (tx_valid && tx_ready) begin
                acc[idx] = tx_bit;
                check("tx_last position", tx_last, (idx == DW - 1));
                if (tx_last || idx == DW - 1) begin
                    last_tx_cyc = cyc;
                    if (sb.size() > 0) check("result", acc, sb.pop_front());
                    idx = 0;
                    acc = '0;
                end else begin
                    idx++;
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_bit = tx_bit;
            prev_last = tx_last;
        end
    end

    task automatic send_packet(input alu_op_e op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input logic a_hi, input logic b_hi, input bit gaps,
                               input int abort_after);
        alu_packet_t p;
        logic [PW-1:0] bits;
        p.op_code = op;
        p.op_1 = {a_hi, a};
        p.op_2 = {b_hi, b};
        bits = p;
        for (int i = 0; i < PW; i++) begin
            int g;
            int w;
            if (abort_after >= 0 && i == abort_after) return;
            g = (gaps && $urandom_range(1) == 1) ? int'($urandom_range(1, 3)) : 0;
            repeat (g) begin
                rx_valid = 1'b0;
                rx_bit = 1'($urandom_range(1));
                @(posedge clk);
                #1;
            end
            rx_valid = 1'b1;
            rx_bit = bits[i];
            w = 0;
            forever begin
                @(negedge clk);
                if (rx_ready) break;
                w++;
                if (w > 300) begin
                    check("rx_ready wait timeout", rx_ready, 1'b1);
                    rx_valid = 1'b0;
                    return;
                end
                @(posedge clk);
                #1;
            end
            if (i == 0) first_accept_cyc = cyc;
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        sb.push_back(model(op, a, b));
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("scoreboard drained", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset rx_ready", rx_ready, 1'b1);
        check("reset tx_valid", tx_valid, 1'b0);
        check("reset tx_bit", tx_bit, 1'b0);
        check("reset tx_last", tx_last, 1'b0);
        check("reset busy", busy, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD 5+3 with latency checks
        send_packet(ALU_ADD, 32'd5, 32'd3, 1'b0, 1'b0, 1'b0, -1);
        @(negedge clk);
        check("execute tx_valid low", tx_valid, 1'b0);
        check("execute rx_ready low", rx_ready, 1'b0);
        check("execute busy", busy, 1'b1);
        @(negedge clk);
        check("tx_valid two edges after last rx", tx_valid, 1'b1);
        drain();

        send_packet(ALU_SUB, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, -1);
        send_packet(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, -1);
        send_packet(ALU_AND, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 1'b0, 1'b0, 1'b0, -1);
        send_packet(ALU_AND, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 1'b1, 1'b1, 1'b0, -1);
        send_packet(ALU_OR,  32'hF0F0_A5A5, 32'h0FF0_FFFF, 1'b0, 1'b0, 1'b0, -1);
        send_packet(ALU_OR,  32'hF0F0_A5A5, 32'h0FF0_FFFF, 1'b1, 1'b1, 1'b0, -1);
        drain();

        // Gaps on rx, 50% stalls on tx, then random traffic
        stall_en = 1'b1;
        send_packet(ALU_ADD, 32'd5, 32'd3, 1'b0, 1'b0, 1'b1, -1);
        for (int k = 0; k < 16; k++) begin
            send_packet(alu_op_e'($urandom_range(3)), $urandom, $urandom,
                        1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1, -1);
        end
        drain();
        stall_en = 1'b0;
        @(posedge clk);
        #1;

        // Reset after 40 packet bits, then a clean OR
        send_packet(ALU_OR, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 40);
        rx_valid = 1'b0;
        check("busy mid-receive", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset rx_ready", rx_ready, 1'b1);
        check("async reset tx_valid", tx_valid, 1'b0);
        check("async reset busy", busy, 1'b0);
        check("async reset tx_last", tx_last, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_packet(ALU_OR, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0, -1);
        drain();

        // Back-to-back: second packet's first bit waits through the first transmit
        send_packet(ALU_SUB, 32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b0, -1);
        send_packet(ALU_AND, 32'hCAFE_F00D, 32'hFF00_FF00, 1'b1, 1'b0, 1'b0, -1);
        check("back-to-back first bit edge", first_accept_cyc, last_tx_cyc + 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
